// File: rtl/srambank_pkg.sv
// Shared definitions for the srambank March C- BIST.
//   bist_state_e : controller states
//   march_elem_e : March C- element index, E0..E5
//   Per-element lookup masks (bit position = element number) and accessors:
//     elem_down     : element walks DEPTH-1 -> 0
//     elem_two_op   : element issues read then write at each address
//     elem_first_rd : first op at each address is a read
//     elem_rd_bg    : background expected by reads (0 = B0, 1 = B1)
//     elem_wr_bg    : background written by writes (0 = B0, 1 = B1)
package srambank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } bist_state_e;

  typedef enum logic [2:0] {
    E0,
    E1,
    E2,
    E3,
    E4,
    E5
  } march_elem_e;

  // Eight bits wide so any 3-bit element index stays in range.
  localparam logic [7:0] ELEM_DOWN     = 8'b0001_1000;  // E3, E4
  localparam logic [7:0] ELEM_TWO_OP   = 8'b0001_1110;  // E1..E4
  localparam logic [7:0] ELEM_FIRST_RD = 8'b0011_1110;  // E1..E5
  localparam logic [7:0] ELEM_RD_BG    = 8'b0001_0100;  // E2, E4 read B1
  localparam logic [7:0] ELEM_WR_BG    = 8'b0000_1010;  // E1, E3 write B1

  function automatic logic elem_down(input march_elem_e e);
    return ELEM_DOWN[e];
  endfunction

  function automatic logic elem_two_op(input march_elem_e e);
    return ELEM_TWO_OP[e];
  endfunction

  function automatic logic elem_first_rd(input march_elem_e e);
    return ELEM_FIRST_RD[e];
  endfunction

  function automatic logic elem_rd_bg(input march_elem_e e);
    return ELEM_RD_BG[e];
  endfunction

  function automatic logic elem_wr_bg(input march_elem_e e);
    return ELEM_WR_BG[e];
  endfunction

endpackage

// File: rtl/srambank_bist_check.sv
// Read-data checker for the srambank BIST.
// Compares bank dataout against the expected word registered one cycle
// earlier and keeps the sticky fail flag plus first-failure capture.
// Ports:
//   clk, reset_n  : clock, synchronous active-low reset
//   clear_i       : a new run is starting; wipe fail and capture
//   vld_i         : a read was issued last cycle, dataout is meaningful
//   exp_i         : expected word for that read
//   addr_i        : address of that read
//   elem_i        : March element of that read
//   dout_i        : bank dataout
//   fail_o        : sticky mismatch flag
//   fail_addr_o   : address of first mismatch
//   fail_elem_o   : element of first mismatch
//   fail_data_o   : dataout seen at first mismatch
module srambank_bist_check
  import srambank_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_i,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] exp_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  march_elem_e       elem_i,
  input  logic [DATA_W-1:0] dout_i,
  output logic              fail_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [2:0]        fail_elem_o,
  output logic [DATA_W-1:0] fail_data_o
);

  logic              fail_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [2:0]        fail_elem_q;
  logic [DATA_W-1:0] fail_data_q;
  logic              mismatch;

  assign mismatch = vld_i && (dout_i != exp_i);

  // Capture stage: only the first mismatch of a run is recorded.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_data_q <= '0;
    end else if (clear_i) begin
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_data_q <= '0;
    end else if (mismatch && !fail_q) begin
      fail_q      <= 1'b1;
      fail_addr_q <= addr_i;
      fail_elem_q <= elem_i;
      fail_data_q <= dout_i;
    end
  end

  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_elem_o = fail_elem_q;
  assign fail_data_o = fail_data_q;

endmodule

// File: rtl/srambank_bist_ctrl.sv
// March C- BIST initiator for one srambank_128x4x16 bank.
// Drives the bank one op per cycle while busy, checks each read the cycle
// after it is issued, and reports pass/fail with first-failure details.
// Ports:
//   clk, reset_n         : clock (shared with bank), sync active-low reset
//   start                : begin a run (honoured only in IDLE or DONE)
//   busy, done           : run in progress / run complete (held)
//   fail, fail_addr,
//   fail_elem, fail_data : sticky failure flag and first-failure capture
//   ADDRESS, wd, banksel,
//   read, write          : registered bank controls
//   dataout              : bank read data, valid the cycle after a read
module srambank_bist_ctrl
  import srambank_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data,
  output logic [ADDR_W-1:0] ADDRESS,
  output logic [DATA_W-1:0] wd,
  output logic              banksel,
  output logic              read,
  output logic              write,
  input  logic [DATA_W-1:0] dataout
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  bist_state_e       state_q, state_d;
  // Counters point at the next op to issue.
  march_elem_e       elem_q, elem_d;
  logic              phase_q, phase_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  march_elem_e       op_elem_q, op_elem_d;

  logic [DATA_W-1:0] rexp_p0, rexp_d;
  logic              vld_p1;
  logic [DATA_W-1:0] exp_p1;
  logic [ADDR_W-1:0] addr_p1;
  march_elem_e       elem_p1;

  logic              clear_run;
  logic              issue;
  logic              last_presented;
  march_elem_e       src_elem;
  logic              src_phase;
  logic [ADDR_W-1:0] src_addr;
  logic              src_down;
  logic              src_rd;
  logic              src_end;

  // The op on the bank pins right now is the final E5 read.
  assign last_presented = rd_q && (op_elem_q == E5) && (adr_q == LAST_ADDR);

  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    phase_d   = phase_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    done_d    = done_q;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    adr_d     = '0;
    wd_d      = '0;
    op_elem_d = op_elem_q;
    rexp_d    = '0;
    clear_run = 1'b0;
    issue     = 1'b0;
    src_elem  = elem_q;
    src_phase = phase_q;
    src_addr  = addr_q;
    src_down  = 1'b0;
    src_rd    = 1'b0;
    src_end   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Issue the first E0 write straight from constants so it
          // reaches the pins the cycle after start.
          state_d   = RUN;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          clear_run = 1'b1;
          issue     = 1'b1;
          src_elem  = E0;
          src_phase = 1'b0;
          src_addr  = '0;
        end
      end
      RUN: begin
        if (last_presented) begin
          state_d = DRAIN;
        end else begin
          issue = 1'b1;
        end
      end
      DRAIN: begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      src_down  = elem_down(src_elem);
      src_rd    = elem_first_rd(src_elem) && !src_phase;
      rd_d      = src_rd;
      wr_d      = !src_rd;
      adr_d     = src_addr;
      op_elem_d = src_elem;
      wd_d      = {DATA_W{!src_rd && elem_wr_bg(src_elem)}};
      rexp_d    = {DATA_W{elem_rd_bg(src_elem)}};
      src_end   = (src_addr == (src_down ? '0 : LAST_ADDR));

      if (elem_two_op(src_elem) && !src_phase) begin
        elem_d  = src_elem;
        phase_d = 1'b1;
        addr_d  = src_addr;
      end else begin
        phase_d = 1'b0;
        if (src_end) begin
          // E5 is last; the RUN exit is taken from the pins, so the
          // counters just park here.
          elem_d = (src_elem == E5) ? E5 : march_elem_e'(src_elem + 3'd1);
          addr_d = elem_down(elem_d) ? LAST_ADDR : '0;
        end else begin
          elem_d = src_elem;
          addr_d = src_down ? (src_addr - 1'b1) : (src_addr + 1'b1);
        end
      end
    end
  end

  // Stage p0: op registered onto the bank pins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      elem_q    <= E0;
      phase_q   <= 1'b0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      adr_q     <= '0;
      wd_q      <= '0;
      op_elem_q <= E0;
      vld_p1    <= 1'b0;
    end else begin
      state_q   <= state_d;
      elem_q    <= elem_d;
      phase_q   <= phase_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      adr_q     <= adr_d;
      wd_q      <= wd_d;
      op_elem_q <= op_elem_d;
      vld_p1    <= rd_q;
    end
  end

  // Stage p1: read context follows the op by one cycle to meet dataout.
  always_ff @(posedge clk) begin
    rexp_p0 <= rexp_d;
    exp_p1  <= rexp_p0;
    addr_p1 <= adr_q;
    elem_p1 <= op_elem_q;
  end

  srambank_bist_check #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_check (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (clear_run),
    .vld_i       (vld_p1),
    .exp_i       (exp_p1),
    .addr_i      (addr_p1),
    .elem_i      (elem_p1),
    .dout_i      (dataout),
    .fail_o      (fail),
    .fail_addr_o (fail_addr),
    .fail_elem_o (fail_elem),
    .fail_data_o (fail_data)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign ADDRESS = adr_q;
  assign wd      = wd_q;
  assign read    = rd_q;
  assign write   = wr_q;
  assign banksel = rd_q | wr_q;

endmodule

// File: tb/tb_srambank_bist_ctrl.sv
// Bench for srambank_bist_ctrl: behavioural bank with per-address
// stuck-at masks, a table of fault scenarios, and hand-written sequences
// for mid-run reset and start handling.
module tb_srambank_bist_ctrl;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 512;
  localparam int BOUND  = 7000;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              busy, done, fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [2:0]        fail_elem;
  logic [DATA_W-1:0] fail_data;
  logic [ADDR_W-1:0] ADDRESS;
  logic [DATA_W-1:0] wd;
  logic              banksel, read, write;
  logic [DATA_W-1:0] dataout = '0;

  always #5 clk = ~clk;

  srambank_bist_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .fail_data (fail_data),
    .ADDRESS   (ADDRESS),
    .wd        (wd),
    .banksel   (banksel),
    .read      (read),
    .write     (write),
    .dataout   (dataout)
  );

  // Bank model: stuck-at-1 / stuck-at-0 masks applied on read.
  logic [DATA_W-1:0] mem   [DEPTH];
  logic [DATA_W-1:0] sa1_m [DEPTH];
  logic [DATA_W-1:0] sa0_m [DEPTH];

  always @(posedge clk) begin
    if (banksel && write) mem[ADDRESS] <= wd;
    if (banksel && read) dataout <= (mem[ADDRESS] | sa1_m[ADDRESS]) & ~sa0_m[ADDRESS];
  end

  // Cycle / op counters, cleared by the stimulus thread via cnt_clr.
  logic cnt_clr = 1'b1;
  int   busy_cyc = 0;
  int   rd_ops = 0;
  int   wr_ops = 0;

  always @(posedge clk) begin
    if (cnt_clr) begin
      busy_cyc <= 0;
      rd_ops   <= 0;
      wr_ops   <= 0;
    end else begin
      busy_cyc <= busy_cyc + (busy ? 1 : 0);
      rd_ops   <= rd_ops + (read ? 1 : 0);
      wr_ops   <= wr_ops + (write ? 1 : 0);
    end
  end

  // Per-cycle protocol invariants.
  int asrt_errs = 0;
  always @(negedge clk) begin
    int e;
    e = 0;
    if (read && write) begin
      e++;
      $display("FAIL assert_rd_wr: read=%0b write=%0b required not both 1", read, write);
    end
    if (banksel != (read | write)) begin
      e++;
      $display("FAIL assert_banksel: banksel=%0b required %0b", banksel, read | write);
    end
    if (int'(ADDRESS) >= DEPTH) begin
      e++;
      $display("FAIL assert_addr: ADDRESS=%0d required < %0d", ADDRESS, DEPTH);
    end
    if (busy && done) begin
      e++;
      $display("FAIL assert_busy_done: busy=1 done=1 required not both");
    end
    asrt_errs <= asrt_errs + e;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] fa0;
    logic [DATA_W-1:0] sa1_0;
    logic [DATA_W-1:0] sa0_0;
    logic [ADDR_W-1:0] fa1;
    logic [DATA_W-1:0] sa1_1;
    logic [DATA_W-1:0] sa0_1;
    logic              efail;
    logic [ADDR_W-1:0] eaddr;
    logic [2:0]        eelem;
    logic [DATA_W-1:0] edata;
  } vec_t;

  vec_t vecs [6];

  task automatic set_faults(input vec_t v);
    for (int i = 0; i < DEPTH; i++) begin
      sa1_m[i] = '0;
      sa0_m[i] = '0;
    end
    sa1_m[v.fa0] = sa1_m[v.fa0] | v.sa1_0;
    sa0_m[v.fa0] = sa0_m[v.fa0] | v.sa0_0;
    sa1_m[v.fa1] = sa1_m[v.fa1] | v.sa1_1;
    sa0_m[v.fa1] = sa0_m[v.fa1] | v.sa0_1;
  endtask

  // Clear counters, pulse start, check the first op is on the pins.
  task automatic launch();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    chk("first_op", {busy, done, fail, write, read, banksel, ADDRESS, wd},
        {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9'h000, 16'h0000});
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", done, 1);
  endtask

  function automatic logic [63:0] all_outs();
    return {5'd0, busy, done, fail, fail_addr, fail_elem, fail_data,
            ADDRESS, wd, banksel, read, write};
  endfunction

  vec_t clean;

  initial begin
    clean = '{9'h000, 16'h0, 16'h0, 9'h000, 16'h0, 16'h0, 1'b0, 9'h000, 3'd0, 16'h0000};
    vecs[0] = clean;
    vecs[1] = '{9'h005, 16'h0008, 16'h0, 9'h000, 16'h0, 16'h0, 1'b1, 9'h005, 3'd1, 16'h0008};
    vecs[2] = '{9'h1FF, 16'h0, 16'h0001, 9'h000, 16'h0, 16'h0, 1'b1, 9'h1FF, 3'd2, 16'hFFFE};
    vecs[3] = '{9'h010, 16'h0004, 16'h0, 9'h020, 16'h0004, 16'h0, 1'b1, 9'h010, 3'd1, 16'h0004};
    vecs[4] = '{9'h100, 16'h0, 16'h8000, 9'h000, 16'h0, 16'h0, 1'b1, 9'h100, 3'd2, 16'h7FFF};
    vecs[5] = '{9'h000, 16'h0001, 16'h0, 9'h000, 16'h0, 16'h0, 1'b1, 9'h000, 3'd1, 16'h0001};

    reset_n = 1'b0;
    start   = 1'b0;
    set_faults(clean);
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 64'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", all_outs(), 64'h0);

    for (int v = 0; v < 6; v++) begin
      set_faults(vecs[v]);
      launch();
      wait_done();
      chk($sformatf("v%0d_busy_cycles", v), busy_cyc, 5121);
      chk($sformatf("v%0d_reads", v), rd_ops, 2560);
      chk($sformatf("v%0d_writes", v), wr_ops, 2560);
      chk($sformatf("v%0d_busy_low", v), busy, 0);
      chk($sformatf("v%0d_fail", v), fail, vecs[v].efail);
      chk($sformatf("v%0d_fail_addr", v), fail_addr, vecs[v].eaddr);
      chk($sformatf("v%0d_fail_elem", v), fail_elem, vecs[v].eelem);
      chk($sformatf("v%0d_fail_data", v), fail_data, vecs[v].edata);
    end

    // Reset in the middle of a run, with start asserted alongside it.
    set_faults(vecs[1]);
    launch();
    repeat (999) @(negedge clk);
    reset_n = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    chk("midrun_reset_outputs", all_outs(), 64'h0);
    reset_n = 1'b1;
    start   = 1'b0;
    @(negedge clk);
    chk("start_during_reset_ignored", all_outs(), 64'h0);
    set_faults(clean);
    launch();
    wait_done();
    chk("after_reset_busy_cycles", busy_cyc, 5121);
    chk("after_reset_fail", fail, 0);

    // start pulsed while busy, then held high into DONE.
    set_faults(vecs[1]);
    launch();
    repeat (100) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_run_busy", {busy, done}, 2'b10);
    repeat (3800) @(negedge clk);
    start = 1'b1;
    wait_done();
    chk("held_start_busy_cycles", busy_cyc, 5121);
    chk("run1_fail", {fail, fail_addr}, {1'b1, 9'h005});
    @(negedge clk);
    chk("restart_state", {busy, done, fail, write, read, ADDRESS, wd},
        {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 16'h0000});
    start = 1'b0;
    wait_done();
    chk("run2_fail", {fail, fail_addr, fail_elem}, {1'b1, 9'h005, 3'd1});

    chk("assert_violations", asrt_errs, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
